ibex_mult_pext_seq: RTL and testbench
=====================================

Name: ibex_mult_pext_seq

Overview:
- Sequencing FSM for the shared P-extension multiplier datapath.
- Consumes the decoded cycle count and subtract controls for the current multiply op. Drives per-cycle partial-product step selects, intermediate-register write enables and the result handshake to ID/EX.
- Holds a finished result when the consumer stalls; aborts cleanly when the request drops.
- Keeps a saturating completed-op counter for performance monitoring.

Parameters:
CntWidth, 16, width of the saturating completed-op counter ops_done_o.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
mult_en_i  in  1  op request; held high with stable operands until handshake; deassert = abort
cycle_count_i  in  2  decoded length: 2'b00 = 1 cycle, 2'b01 = 2 cycles, 2'b11 = 3 cycles, 2'b10 treated as 2'b00
accum_sub_i  in  2  [1] subtract in 32x32 accumulate step, [0] subtract in single-cycle 32x16 accumulate
ready_i  in  1  consumer accepts result this cycle
clr_cnt_i  in  1  synchronous clear of ops_done_o
step_o  out  2  partial select: 0 = A x B_lo, 1 = A x B_hi + (imd >> 16), 2 = rd +/- imd
imd_we_o  out  1  write intermediate register this cycle
imd_sel_o  out  1  datapath adder uses intermediate register
hold_sel_o  out  1  result mux takes intermediate register (held result)
sub_o  out  1  accumulate step subtracts
valid_o  out  1  result valid this cycle
busy_o  out  1  FSM not in IDLE
ops_done_o  out  CntWidth  saturating count of completed handshakes

Behaviour:
- States: IDLE, STEP1, STEP2, WAIT. Reset state: IDLE.
- Registered state at reset: ops_done_o = 0, latched length = 0, latched sub = 0.
- Combinational outputs in IDLE with mult_en_i low: step_o = 0 and all single-bit outputs = 0.
- Latching: len and sub = accum_sub_i[1] are captured on the IDLE cycle that starts a multi-cycle op. Later changes to cycle_count_i and accum_sub_i are ignored until the FSM returns to IDLE.
- IDLE, mult_en_i = 1:
  - step_o = 0.
  - Length 1: valid_o = 1 and sub_o = accum_sub_i[0]. If ready_i, stay in IDLE. Otherwise imd_we_o = 1 and go to WAIT.
  - Length 2 or 3: imd_we_o = 1, go to STEP1.
- STEP1:
  - step_o = 1, imd_sel_o = 1.
  - Length 3: imd_we_o = 1, go to STEP2.
  - Length 2: this is the final step, handled by the final-step rule below.
- STEP2:
  - step_o = 2, imd_sel_o = 1, sub_o = latched sub.
  - Final step, handled by the final-step rule below.
- Final step rule (STEP1 for length 2, STEP2 for length 3):
  - valid_o = 1.
  - If ready_i, go to IDLE. Otherwise imd_we_o = 1 (capture result) and go to WAIT.
- WAIT:
  - valid_o = 1, hold_sel_o = 1, imd_we_o = 0, step_o = 0.
  - ready_i: go to IDLE.
- Abort: mult_en_i = 0 in STEP1, STEP2 or WAIT.
  - Next state is IDLE.
  - valid_o, imd_we_o and sub_o are forced to 0 in that cycle.
  - Counter does not increment.
- busy_o = 1 in every state except IDLE.
- Back-to-back ops: handshake in a final step or WAIT returns to IDLE. A new op starts on the following cycle; there is no same-cycle restart.
- ops_done_o:
  - Increments by 1 on valid_o && ready_i.
  - Saturates at all-ones.
  - clr_cnt_i has priority over increment; the next value is 0.
- Reset asserted mid-op: immediate return to IDLE. All outputs take their IDLE or reset values with no clock edge required.

Test Plan:
- Single-cycle op: reset, mult_en_i = 1, cycle_count_i = 00, accum_sub_i = 01, ready_i = 1 -> same cycle valid_o = 1, sub_o = 1, step_o = 0; busy_o stays 0; ops_done_o = 1 next cycle.
- 3-cycle op with stall: cycle_count_i = 11, accum_sub_i = 10, ready_i = 0 until cycle 5 ->
  - step_o sequence 0, 1, 2; imd_we_o = 1 in cycles 1, 2, 3.
  - sub_o = 1 only in cycle 3; valid_o = 1 in cycles 3-5; hold_sel_o = 1 in cycles 4-5.
  - IDLE at cycle 6; ops_done_o = 1.
- Latch check: 2-cycle op, cycle_count_i changed to 11 during STEP1 with ready_i = 1 -> valid_o in cycle 2 and return to IDLE; no STEP2.
- Abort: 3-cycle op, mult_en_i dropped in STEP2 -> valid_o = 0 that cycle, IDLE next cycle, ops_done_o unchanged.
- Saturation and clear: CntWidth = 2, 5 single-cycle handshakes -> ops_done_o = 3; clr_cnt_i together with a handshake -> ops_done_o = 0.
- Async reset: rst_ni pulsed low mid-STEP1 between clock edges -> busy_o = 0 and imd_we_o = 0 immediately, ops_done_o = 0.

Source files
------------

// File: rtl/ibex_mult_pext_seq.sv
// Step sequencer for the shared P-extension multiplier: 1 to 3 cycles per op, result valid in the final step.
// Backpressure: an unaccepted result is parked in the intermediate register and held in WAIT until ready_i.
module ibex_mult_pext_seq #(
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                mult_en_i,
    input  logic [1:0]          cycle_count_i,
    input  logic [1:0]          accum_sub_i,
    input  logic                ready_i,
    input  logic                clr_cnt_i,
    output logic [1:0]          step_o,
    output logic                imd_we_o,
    output logic                imd_sel_o,
    output logic                hold_sel_o,
    output logic                sub_o,
    output logic                valid_o,
    output logic                busy_o,
    output logic [CntWidth-1:0] ops_done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STEP1 = 2'd1,
        S_STEP2 = 2'd2,
        S_WAIT  = 2'd3
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [1:0]          r_len;
    logic                r_sub;
    logic [CntWidth-1:0] r_ops_done;

    logic [1:0] w_len;
    logic       w_latch;
    logic [1:0] w_step;
    logic       w_imd_we;
    logic       w_imd_sel;
    logic       w_hold_sel;
    logic       w_sub;
    logic       w_valid;
    logic       w_hs;

    // The unused 2'b10 encoding aliases to the single-cycle form.
    assign w_len = (cycle_count_i == 2'b10) ? 2'b00 : cycle_count_i;

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_step      = 2'd0;
        w_imd_we    = 1'b0;
        w_imd_sel   = 1'b0;
        w_hold_sel  = 1'b0;
        w_sub       = 1'b0;
        w_valid     = 1'b0;
        // Outputs stay quiet while reset is held, even with a request pending.
        if (rst_ni) begin
            case (r_state)
                S_IDLE: begin
                    if (mult_en_i) begin
                        if (w_len == 2'b00) begin
                            w_valid = 1'b1;
                            w_sub   = accum_sub_i[0];
                            if (!ready_i) begin
                                w_imd_we    = 1'b1;
                                w_state_nxt = S_WAIT;
                            end
                        end else begin
                            w_imd_we    = 1'b1;
                            w_latch     = 1'b1;
                            w_state_nxt = S_STEP1;
                        end
                    end
                end
                S_STEP1: begin
                    w_step    = 2'd1;
                    w_imd_sel = 1'b1;
                    if (!mult_en_i) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_len == 2'b11) begin
                        w_imd_we    = 1'b1;
                        w_state_nxt = S_STEP2;
                    end else begin
                        w_valid = 1'b1;
                        if (ready_i) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_imd_we    = 1'b1;
                            w_state_nxt = S_WAIT;
                        end
                    end
                end
                S_STEP2: begin
                    w_step    = 2'd2;
                    w_imd_sel = 1'b1;
                    if (!mult_en_i) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_sub   = r_sub;
                        w_valid = 1'b1;
                        if (ready_i) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_imd_we    = 1'b1;
                            w_state_nxt = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    w_hold_sel = 1'b1;
                    if (!mult_en_i) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_valid = 1'b1;
                        if (ready_i) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_hs = w_valid & ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_len      <= 2'b00;
            r_sub      <= 1'b0;
            r_ops_done <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_len <= w_len;
                r_sub <= accum_sub_i[1];
            end
            if (clr_cnt_i) begin
                r_ops_done <= '0;
            end else if (w_hs && (r_ops_done != {CntWidth{1'b1}})) begin
                r_ops_done <= r_ops_done + 1'b1;
            end
        end
    end

    assign step_o     = w_step;
    assign imd_we_o   = w_imd_we;
    assign imd_sel_o  = w_imd_sel;
    assign hold_sel_o = w_hold_sel;
    assign sub_o      = w_sub;
    assign valid_o    = w_valid;
    assign busy_o     = rst_ni && (r_state != S_IDLE);
    assign ops_done_o = r_ops_done;

endmodule

// File: tb/tb_ibex_mult_pext_seq.sv
// Directed bench for ibex_mult_pext_seq; a CntWidth=2 copy shares stimulus to exercise saturation.
module tb_ibex_mult_pext_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mult_en_i = 1'b0;
    logic [1:0]  cycle_count_i = 2'b00;
    logic [1:0]  accum_sub_i = 2'b00;
    logic        ready_i = 1'b0;
    logic        clr_cnt_i = 1'b0;

    logic [1:0]  step_a, step_b;
    logic        we_a, we_b, isel_a, isel_b, hold_a, hold_b;
    logic        sub_a, sub_b, valid_a, valid_b, busy_a, busy_b;
    logic [15:0] ops_a;
    logic [1:0]  ops_b;

    int errors = 0;
    int checks = 0;
    int exp16  = 0;

    always #5 clk_i = ~clk_i;

    ibex_mult_pext_seq u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .mult_en_i(mult_en_i),
        .cycle_count_i(cycle_count_i), .accum_sub_i(accum_sub_i),
        .ready_i(ready_i), .clr_cnt_i(clr_cnt_i),
        .step_o(step_a), .imd_we_o(we_a), .imd_sel_o(isel_a),
        .hold_sel_o(hold_a), .sub_o(sub_a), .valid_o(valid_a),
        .busy_o(busy_a), .ops_done_o(ops_a)
    );

    ibex_mult_pext_seq #(.CntWidth(2)) u_dut2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .mult_en_i(mult_en_i),
        .cycle_count_i(cycle_count_i), .accum_sub_i(accum_sub_i),
        .ready_i(ready_i), .clr_cnt_i(clr_cnt_i),
        .step_o(step_b), .imd_we_o(we_b), .imd_sel_o(isel_b),
        .hold_sel_o(hold_b), .sub_o(sub_b), .valid_o(valid_b),
        .busy_o(busy_b), .ops_done_o(ops_b)
    );

    // Observation vector: {step[1:0], imd_we, imd_sel, hold_sel, sub, valid, busy}
    wire [7:0] obs_a = {step_a, we_a, isel_a, hold_a, sub_a, valid_a, busy_a};
    wire [7:0] obs_b = {step_b, we_b, isel_b, hold_b, sub_b, valid_b, busy_b};

    function automatic int sat2(input int n);
        return (n > 3) ? 3 : n;
    endfunction

    // Input vector: {clr, en, cycle_count[1:0], accum_sub[1:0], ready}
    task automatic drive(input logic [6:0] in);
        @(posedge clk_i);
        #1;
        {clr_cnt_i, mult_en_i, cycle_count_i, accum_sub_i, ready_i} = in;
        @(negedge clk_i);
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (obs_a !== 8'b0 || obs_b !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs obs=%b/%b exp=00000000", obs_a, obs_b);
        end
        checks++;
        if (ops_a !== 16'd0 || ops_b !== 2'd0) begin
            errors++;
            $display("FAIL reset_count got=%0d/%0d exp=0", ops_a, ops_b);
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_single;
        logic [14:0] v [3];
        v = '{{7'b0_1_00_01_1, 8'b00000110},
              {7'b0_1_10_00_1, 8'b00000010},
              {7'b0_0_00_00_0, 8'b00000000}};
        for (int i = 0; i < 3; i++) begin
            drive(v[i][14:8]);
            checks++;
            if (obs_a !== v[i][7:0] || obs_b !== v[i][7:0]) begin
                errors++;
                $display("FAIL single c%0d obs=%b/%b exp=%b", i, obs_a, obs_b, v[i][7:0]);
            end
        end
        exp16 += 2;
        checks++;
        if (ops_a !== 16'(exp16) || ops_b !== 2'(sat2(exp16))) begin
            errors++;
            $display("FAIL single_count got=%0d/%0d exp=%0d", ops_a, ops_b, exp16);
        end
    endtask

    task automatic test_three_stall;
        logic [14:0] v [6];
        v = '{{7'b0_1_11_10_0, 8'b00100000},
              {7'b0_1_00_00_0, 8'b01110001},
              {7'b0_1_00_00_0, 8'b10110111},
              {7'b0_1_00_00_0, 8'b00001011},
              {7'b0_1_00_00_1, 8'b00001011},
              {7'b0_0_00_00_0, 8'b00000000}};
        for (int i = 0; i < 6; i++) begin
            drive(v[i][14:8]);
            checks++;
            if (obs_a !== v[i][7:0] || obs_b !== v[i][7:0]) begin
                errors++;
                $display("FAIL three_stall c%0d obs=%b/%b exp=%b", i + 1, obs_a, obs_b, v[i][7:0]);
            end
        end
        exp16 += 1;
        checks++;
        if (ops_a !== 16'(exp16) || ops_b !== 2'(sat2(exp16))) begin
            errors++;
            $display("FAIL three_count got=%0d/%0d exp=%0d", ops_a, ops_b, exp16);
        end
    endtask

    task automatic test_latch;
        logic [14:0] v [3];
        v = '{{7'b0_1_01_00_1, 8'b00100000},
              {7'b0_1_11_00_1, 8'b01010011},
              {7'b0_0_11_00_0, 8'b00000000}};
        for (int i = 0; i < 3; i++) begin
            drive(v[i][14:8]);
            checks++;
            if (obs_a !== v[i][7:0] || obs_b !== v[i][7:0]) begin
                errors++;
                $display("FAIL latch c%0d obs=%b/%b exp=%b", i + 1, obs_a, obs_b, v[i][7:0]);
            end
        end
        exp16 += 1;
        checks++;
        if (ops_a !== 16'(exp16) || ops_b !== 2'(sat2(exp16))) begin
            errors++;
            $display("FAIL latch_count got=%0d/%0d exp=%0d", ops_a, ops_b, exp16);
        end
    endtask

    task automatic test_abort;
        logic [14:0] v [7];
        v = '{{7'b0_1_11_10_0, 8'b00100000},
              {7'b0_1_11_10_0, 8'b01110001},
              {7'b0_0_11_10_0, 8'b10010001},
              {7'b0_0_00_00_0, 8'b00000000},
              {7'b0_1_00_00_0, 8'b00100010},
              {7'b0_0_00_00_0, 8'b00001001},
              {7'b0_0_00_00_0, 8'b00000000}};
        for (int i = 0; i < 7; i++) begin
            drive(v[i][14:8]);
            checks++;
            if (obs_a !== v[i][7:0] || obs_b !== v[i][7:0]) begin
                errors++;
                $display("FAIL abort c%0d obs=%b/%b exp=%b", i + 1, obs_a, obs_b, v[i][7:0]);
            end
        end
        checks++;
        if (ops_a !== 16'(exp16) || ops_b !== 2'(sat2(exp16))) begin
            errors++;
            $display("FAIL abort_count got=%0d/%0d exp=%0d", ops_a, ops_b, exp16);
        end
    endtask

    task automatic test_back_to_back;
        logic [14:0] v [4];
        v = '{{7'b0_1_01_00_1, 8'b00100000},
              {7'b0_1_01_00_1, 8'b01010011},
              {7'b0_1_00_01_1, 8'b00000110},
              {7'b0_0_00_00_0, 8'b00000000}};
        for (int i = 0; i < 4; i++) begin
            drive(v[i][14:8]);
            checks++;
            if (obs_a !== v[i][7:0] || obs_b !== v[i][7:0]) begin
                errors++;
                $display("FAIL back_to_back c%0d obs=%b/%b exp=%b", i + 1, obs_a, obs_b, v[i][7:0]);
            end
        end
        exp16 += 2;
        checks++;
        if (ops_a !== 16'(exp16) || ops_b !== 2'(sat2(exp16))) begin
            errors++;
            $display("FAIL b2b_count got=%0d/%0d exp=%0d", ops_a, ops_b, exp16);
        end
    endtask

    task automatic test_sat_clear;
        drive(7'b1_0_00_00_0);
        exp16 = 0;
        for (int i = 0; i < 5; i++) begin
            drive(7'b0_1_00_00_1);
            checks++;
            if (obs_a !== 8'b00000010 || obs_b !== 8'b00000010) begin
                errors++;
                $display("FAIL sat_hs%0d obs=%b/%b exp=00000010", i, obs_a, obs_b);
            end
        end
        drive(7'b0_0_00_00_0);
        exp16 = 5;
        checks++;
        if (ops_a !== 16'd5) begin
            errors++;
            $display("FAIL count16_after5 got=%0d exp=5", ops_a);
        end
        checks++;
        if (ops_b !== 2'd3) begin
            errors++;
            $display("FAIL count2_saturate got=%0d exp=3", ops_b);
        end
        drive(7'b1_1_00_00_1);
        drive(7'b0_0_00_00_0);
        exp16 = 0;
        checks++;
        if (ops_a !== 16'd0 || ops_b !== 2'd0) begin
            errors++;
            $display("FAIL clear_priority got=%0d/%0d exp=0", ops_a, ops_b);
        end
    endtask

    task automatic test_async_reset;
        drive(7'b0_1_11_00_0);
        drive(7'b0_1_11_00_0);
        checks++;
        if (obs_a !== 8'b01110001) begin
            errors++;
            $display("FAIL pre_reset_step1 obs=%b exp=01110001", obs_a);
        end
        #1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (obs_a !== 8'b0 || obs_b !== 8'b0) begin
            errors++;
            $display("FAIL async_reset_outputs obs=%b/%b exp=00000000", obs_a, obs_b);
        end
        checks++;
        if (busy_a !== 1'b0 || we_a !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_busy_we got=%b%b exp=00", busy_a, we_a);
        end
        checks++;
        if (ops_a !== 16'd0 || ops_b !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_count got=%0d/%0d exp=0", ops_a, ops_b);
        end
        @(posedge clk_i);
        #1;
        mult_en_i = 1'b0;
        rst_ni    = 1'b1;
        drive(7'b0_0_00_00_0);
        checks++;
        if (obs_a !== 8'b0) begin
            errors++;
            $display("FAIL post_reset_idle obs=%b exp=00000000", obs_a);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three_stall();
        test_latch();
        test_abort();
        test_back_to_back();
        test_sat_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
